// File: rtl/copy_verify_module.sv
// Post-copy verifier: walks every address, reads ROM and RAM in parallel and
// compares each word pair, then reports pass/fail, error count and first bad address.
module copy_verify_module #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_sig,
  output logic              done_sig,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_data,
  output logic              pass_sig,
  output logic [ADDR_W:0]   err_cnt,
  output logic [ADDR_W-1:0] first_err_addr
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned TAGS  = RD_LAT + 1;
  localparam int unsigned DRN_W = 2;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    DRAIN,
    REPORT,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_d;
  logic [DRN_W-1:0]  drain_cnt_q, drain_cnt_d;
  logic [ADDR_W-1:0] addr_d;
  logic              issue_c;
  logic              clear_c;
  logic              report_c;
  logic              done_d;
  logic              mismatch_c;

  logic [TAGS-1:0]   tag_vld_q;
  logic [ADDR_W-1:0] tag_addr_q [TAGS];

  // Oldest tag lines up with the data returned for its address
  assign mismatch_c = tag_vld_q[TAGS-1] && (rom_data != ram_data);

  // Next-state and per-cycle controls; a low start_sig holds every non-idle state
  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    drain_cnt_d = drain_cnt_q;
    addr_d      = rom_addr;
    issue_c     = 1'b0;
    clear_c     = 1'b0;
    report_c    = 1'b0;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_sig) begin
          clear_c     = 1'b1;
          issue_c     = 1'b1;
          addr_d      = '0;
          issue_cnt_d = CNT_W'(1);
          drain_cnt_d = '0;
          state_d     = (DEPTH == 1) ? DRAIN : ISSUE;
        end
      end
      ISSUE: begin
        if (start_sig) begin
          issue_c     = 1'b1;
          addr_d      = issue_cnt_q[ADDR_W-1:0];
          issue_cnt_d = issue_cnt_q + CNT_W'(1);
          if (issue_cnt_q == CNT_W'(DEPTH - 1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (start_sig) begin
          if (drain_cnt_q == DRN_W'(RD_LAT)) state_d = REPORT;
          else drain_cnt_d = drain_cnt_q + DRN_W'(1);
        end
      end
      REPORT: begin
        if (start_sig) begin
          report_c = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (start_sig) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, address and handshake registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      issue_cnt_q <= '0;
      drain_cnt_q <= '0;
      rom_addr    <= '0;
      ram_addr    <= '0;
      done_sig    <= 1'b0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      rom_addr    <= addr_d;
      ram_addr    <= addr_d;
      done_sig    <= done_d;
    end
  end

  // In-flight reads keep draining while paused (memories keep clocking), so
  // a pause inserts bubbles rather than stalling tags against moving data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_vld_q <= '0;
      for (int i = 0; i < int'(TAGS); i++) tag_addr_q[i] <= '0;
    end else begin
      tag_vld_q     <= {tag_vld_q[TAGS-2:0], issue_c};
      tag_addr_q[0] <= addr_d;
      for (int i = 1; i < int'(TAGS); i++) tag_addr_q[i] <= tag_addr_q[i-1];
    end
  end

  // Result accumulation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt        <= '0;
      first_err_addr <= '0;
      pass_sig       <= 1'b0;
    end else if (clear_c) begin
      err_cnt        <= '0;
      first_err_addr <= '0;
      pass_sig       <= 1'b0;
    end else begin
      if (mismatch_c) begin
        if (err_cnt != CNT_W'(DEPTH)) err_cnt <= err_cnt + CNT_W'(1);
        if (err_cnt == '0) first_err_addr <= tag_addr_q[TAGS-1];
      end
      if (report_c) pass_sig <= (err_cnt == '0);
    end
  end

endmodule
